// File: rtl/eig_matrix_sequencer.sv
// rtl/eig_matrix_sequencer.sv - serial operand loader, solver enable timer and result holder for the 2x2 eigen solver
module eig_matrix_sequencer #(
  parameter int DATA_W     = 16,
  parameter int SOLVER_LAT = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] x11,
  output logic [DATA_W-1:0] x12,
  output logic [DATA_W-1:0] x21,
  output logic [DATA_W-1:0] x22,
  output logic              solver_en,
  input  logic [DATA_W-1:0] eig_reel_i,
  input  logic [DATA_W-1:0] eig_comp_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] eig_reel,
  output logic [DATA_W-1:0] eig_comp,
  output logic              busy
);

  // A zero-latency solver makes no sense for this timer; refuse to elaborate.
  if (SOLVER_LAT < 1) begin : g_bad_lat
    $error("eig_matrix_sequencer: SOLVER_LAT must be >= 1");
  end

  localparam int CNT_W = $clog2(SOLVER_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SOLVER_LAT - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [1:0]        idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] x11_q, x12_q, x21_q, x22_q;
  logic [DATA_W-1:0] reel_q, comp_q;
  logic              en_q, ovalid_q;

  // Handshake and status are decoded straight from the state so LOAD accepts immediately.
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);

  assign x11       = x11_q;
  assign x12       = x12_q;
  assign x21       = x21_q;
  assign x22       = x22_q;
  assign solver_en = en_q;
  assign out_valid = ovalid_q;
  assign eig_reel  = reel_q;
  assign eig_comp  = comp_q;

  // Sequencer FSM: collect four elements, time the solver, then hold the result for downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      x11_q    <= '0;
      x12_q    <= '0;
      x21_q    <= '0;
      x22_q    <= '0;
      reel_q   <= '0;
      comp_q   <= '0;
      en_q     <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            case (idx_q)
              2'd0:    x11_q <= in_data;
              2'd1:    x12_q <= in_data;
              2'd2:    x21_q <= in_data;
              default: x22_q <= in_data;
            endcase
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= RUN;
              en_q    <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          // Operands stay frozen; the enable window closes on the same edge the results are taken.
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            reel_q   <= eig_reel_i;
            comp_q   <= eig_comp_i;
            ovalid_q <= 1'b1;
            en_q     <= 1'b0;
            state_q  <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            state_q  <= LOAD;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule
